alarm_sched: RTL and testbench

Alarm sequencing controller for the alarm-clock datapath. It watches the running time (minutes/hours counters) against the alarm registers and drives Buzz. It owns a three-state ring/snooze/idle FSM with a bounded snooze count and an auto-off timeout, and replaces the flat comparator-style alarm module at the top level.

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/rise_det.sv | 20 ++
 rtl/alarm_sched.sv | 132 +++++++++++++
 tb/tb_alarm_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm sequencing controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_RING   = 2'd1,
    A_SNOOZE = 2'd2
  } alarm_state_t;

  localparam int DEF_NS           = 60;
  localparam int DEF_SNOOZE_MIN   = 9;
  localparam int DEF_RING_TIMEOUT = 60;
  localparam int DEF_MAX_SNOOZE   = 3;

  // Keeps vectors at least one bit wide when a parameter collapses to 1.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector: one-cycle pulse on each 0->1 of d.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // NOTE: clocked state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/alarm_sched.sv
// Alarm sequencing controller: IDLE/RING/SNOOZE FSM with bounded snoozes
// and an auto-off timeout, driven by the one-second tick.
module alarm_sched
  import alarm_pkg::*;
#(
  parameter int NS           = DEF_NS,
  parameter int SNOOZE_MIN   = DEF_SNOOZE_MIN,
  parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
  parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [6:0]                      tmin,
  input  logic [6:0]                      thrs,
  input  logic [6:0]                      amin,
  input  logic [6:0]                      ahrs,
  input  logic                            alarm_en,
  input  logic                            snooze_btn,
  input  logic                            off_btn,
  output logic                            buzz,
  output logic                            snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_used,
  output logic [1:0]                      state
);

  localparam int RW = width_of(RING_TIMEOUT);
  localparam int SW = width_of(SNOOZE_MIN * NS + 1);
  localparam int UW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MIN * NS);
  localparam logic [UW-1:0] USED_MAX  = UW'(MAX_SNOOZE);

  alarm_state_t  state_q, state_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [SW-1:0] snz_q, snz_d;
  logic [UW-1:0] used_q, used_d;

  logic match;
  logic trigger;
  logic snz_e;
  logic off_e;

  assign match = alarm_en && (tmin == amin) && (thrs == ahrs);

  // alarm_en is folded into match, so enabling inside the alarm minute
  // still produces an edge and rings.
  rise_det u_match_edge (.clk(clk), .rst(rst), .d(match),      .pulse(trigger));
  rise_det u_snz_edge   (.clk(clk), .rst(rst), .d(snooze_btn), .pulse(snz_e));
  rise_det u_off_edge   (.clk(clk), .rst(rst), .d(off_btn),    .pulse(off_e));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      used_q  <= used_d;
    end
  end

  // NOTE: every combinational output is given a hold value first so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    used_d  = used_q;

    if (!alarm_en) begin
      state_d = A_IDLE;
      ring_d  = '0;
      snz_d   = '0;
      used_d  = '0;
    end else begin
      case (state_q)
        A_IDLE: begin
          if (trigger) begin
            state_d = A_RING;
            ring_d  = '0;
            used_d  = '0;
          end
        end

        A_RING: begin
          // A refused snooze falls through so the tick still counts.
          if (off_e) begin
            state_d = A_IDLE;
            used_d  = '0;
          end else if (snz_e && (used_q < USED_MAX)) begin
            state_d = A_SNOOZE;
            snz_d   = SNZ_LOAD;
            used_d  = used_q + UW'(1);
          end else if (tick) begin
            if (ring_q == RING_LAST) begin
              state_d = A_IDLE;
              used_d  = '0;
            end else begin
              ring_d = ring_q + RW'(1);
            end
          end
        end

        A_SNOOZE: begin
          if (off_e) begin
            state_d = A_IDLE;
          end else if (tick) begin
            if (snz_q == SW'(1)) begin
              state_d = A_RING;
              ring_d  = '0;
            end else if (snz_q != '0) begin
              snz_d = snz_q - SW'(1);
            end
          end
        end

        default: state_d = A_IDLE;
      endcase
    end
  end

  assign buzz        = (state_q == A_RING);
  assign snoozing    = (state_q == A_SNOOZE);
  assign snooze_used = used_q;
  assign state       = state_q;

endmodule

// File: tb/tb_alarm_sched.sv
// Self-checking bench for alarm_sched: scenario tasks push per-cycle
// expectations into a scoreboard that a negedge monitor drains.
module tb_alarm_sched;

  localparam int NS           = 60;
  localparam int SNOOZE_MIN   = 1;
  localparam int RING_TIMEOUT = 5;
  localparam int MAX_SNOOZE   = 2;
  localparam int SNZ_TICKS    = SNOOZE_MIN * NS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_SNZ  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [6:0] tmin = '0;
  logic [6:0] thrs = '0;
  logic [6:0] amin = '0;
  logic [6:0] ahrs = '0;
  logic       alarm_en = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       off_btn = 1'b0;
  logic       buzz;
  logic       snoozing;
  logic [1:0] snooze_used;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic       buzz;
    logic       snz;
    logic [1:0] used;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t sb[$];

  alarm_sched #(
    .NS(NS), .SNOOZE_MIN(SNOOZE_MIN),
    .RING_TIMEOUT(RING_TIMEOUT), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .tmin(tmin), .thrs(thrs), .amin(amin), .ahrs(ahrs),
    .alarm_en(alarm_en), .snooze_btn(snooze_btn), .off_btn(off_btn),
    .buzz(buzz), .snoozing(snoozing), .snooze_used(snooze_used), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares on the falling edge, away from updates.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.tag, e.cyc, cyc);
      end else if ({buzz, snoozing, snooze_used, state} !== {e.buzz, e.snz, e.used, e.st}) begin
        fails++;
        $display("FAIL %s: buzz/snoozing/used/state got %b/%b/%0d/%0d expected %b/%b/%0d/%0d",
                 e.tag, buzz, snoozing, snooze_used, state, e.buzz, e.snz, e.used, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_next(input logic b, input logic s, input logic [1:0] u,
                          input logic [1:0] st, input string tag);
    exp_t e;
    e.cyc = cyc + 1; e.buzz = b; e.snz = s; e.used = u; e.st = st; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  // Starts a fresh ring event from 07:29 -> 07:30.
  task automatic start_ring(input logic [1:0] used_before, input string tag);
    tmin = 7'd30;
    exp_next(1'b1, 1'b0, 2'd0, S_RING, tag);
    cycle();
    tests++;
    if (buzz !== 1'b1 || snooze_used !== 2'd0) begin
      fails++;
      $display("FAIL %s_inline: buzz=%b used=%0d expected buzz=1 used=0 (was %0d)",
               tag, buzz, snooze_used, used_before);
    end
  endtask

  task automatic press_snooze(input logic [1:0] used_after, input string tag);
    snooze_btn = 1'b1;
    exp_next(1'b0, 1'b1, used_after, S_SNZ, tag);
    cycle();
    snooze_btn = 1'b0;
    exp_next(1'b0, 1'b1, used_after, S_SNZ, {tag, "_release"});
    cycle();
  endtask

  task automatic run_snooze(input logic [1:0] used, input string tag);
    for (int i = 1; i <= SNZ_TICKS; i++) begin
      if (i < SNZ_TICKS) exp_next(1'b0, 1'b1, used, S_SNZ, tag);
      else               exp_next(1'b1, 1'b0, used, S_RING, {tag, "_expire"});
      tick_cycle();
    end
  endtask

  task automatic end_minute();
    tmin = 7'd31;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "leave_minute");
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tmin = 7'd29; thrs = 7'd7; amin = 7'd30; ahrs = 7'd7; alarm_en = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "reset_a");
    cycle();
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "reset_b");
    cycle();
    tests++;
    if ({buzz, snoozing, snooze_used, state} !== 6'b0) begin
      fails++;
      $display("FAIL reset_inline: got %b expected 000000", {buzz, snoozing, snooze_used, state});
    end
    rst = 1'b0;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "after_reset");
    cycle();
  endtask

  task automatic test_basic_ring();
    start_ring(2'd0, "ring_on");
    for (int i = 1; i <= RING_TIMEOUT; i++) begin
      if (i < RING_TIMEOUT) exp_next(1'b1, 1'b0, 2'd0, S_RING, "ring_hold");
      else                  exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "auto_off");
      tick_cycle();
    end
    for (int i = 0; i < 20; i++) begin
      exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "no_rering");
      if (i % 4 == 0) tick_cycle();
      else            cycle();
    end
    end_minute();
  endtask

  task automatic test_snooze();
    start_ring(2'd0, "snz_ring");
    press_snooze(2'd1, "snooze1");
    run_snooze(2'd1, "snooze1_wait");
    press_snooze(2'd2, "snooze2");
    run_snooze(2'd2, "snooze2_wait");
    snooze_btn = 1'b1;
    exp_next(1'b1, 1'b0, 2'd2, S_RING, "snooze3_ignored");
    cycle();
    snooze_btn = 1'b0;
    exp_next(1'b1, 1'b0, 2'd2, S_RING, "snooze3_release");
    cycle();
    off_btn = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "off_after_snooze");
    cycle();
    off_btn = 1'b0;
    end_minute();
  endtask

  task automatic test_off_priority();
    start_ring(2'd0, "prio_ring");
    off_btn = 1'b1;
    snooze_btn = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "off_beats_snooze");
    cycle();
    off_btn = 1'b0;
    snooze_btn = 1'b0;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "prio_release");
    cycle();
    end_minute();
  endtask

  task automatic test_held_button();
    start_ring(2'd0, "held_ring");
    snooze_btn = 1'b1;
    exp_next(1'b0, 1'b1, 2'd1, S_SNZ, "held_press");
    cycle();
    for (int i = 1; i <= 100; i++) begin
      if (i < SNZ_TICKS)                         exp_next(1'b0, 1'b1, 2'd1, S_SNZ, "held_snooze");
      else if (i < SNZ_TICKS + RING_TIMEOUT)     exp_next(1'b1, 1'b0, 2'd1, S_RING, "held_ring_again");
      else                                       exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "held_auto_off");
      tick_cycle();
    end
    snooze_btn = 1'b0;
    end_minute();
  endtask

  task automatic test_disable_reset();
    start_ring(2'd0, "dis_ring");
    press_snooze(2'd1, "dis_snooze");
    for (int i = 0; i < 3; i++) begin
      exp_next(1'b0, 1'b1, 2'd1, S_SNZ, "dis_snooze_tick");
      tick_cycle();
    end
    alarm_en = 1'b0;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "disable_mid_snooze");
    cycle();
    tmin = 7'd31;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "disabled_idle");
    cycle();
    alarm_en = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "reenable_no_match");
    cycle();

    start_ring(2'd0, "rst_ring");
    press_snooze(2'd1, "rst_snooze");
    run_snooze(2'd1, "rst_snooze_wait");
    rst = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "reset_mid_ring");
    cycle();
    tmin = 7'd31;
    rst = 1'b0;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "after_mid_reset");
    cycle();
  endtask

  task automatic test_late_enable();
    alarm_en = 1'b0;
    tmin = 7'd30;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "late_off_a");
    cycle();
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "late_off_b");
    cycle();
    alarm_en = 1'b1;
    exp_next(1'b1, 1'b0, 2'd0, S_RING, "late_enable");
    cycle();
    off_btn = 1'b1;
    exp_next(1'b0, 1'b0, 2'd0, S_IDLE, "late_off_press");
    cycle();
    off_btn = 1'b0;
    end_minute();
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_snooze();
    test_off_priority();
    test_held_button();
    test_disable_reset();
    test_late_enable();
    cycle();
    cycle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
